// File: rtl/noise_voice_sequencer.sv
// Time-multiplexed SID-style noise generator: one shared accumulator/LFSR datapath
// serves VOICES voices, one voice per clock, once per sample_tick sweep.
module noise_voice_sequencer #(
    parameter int VOICES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sample_tick,
    input  logic                        freq_wr_en,
    input  logic [$clog2(VOICES)-1:0]   freq_wr_addr,
    input  logic [15:0]                 freq_wr_data,
    input  logic [VOICES-1:0]           test,
    output logic [11:0]                 dout,
    output logic [$clog2(VOICES)-1:0]   dout_voice,
    output logic                        dout_valid,
    output logic                        busy,
    output logic                        overrun
);

    localparam int IW = $clog2(VOICES);
    localparam logic [22:0] SEED = 23'h37242B;
    localparam logic [IW-1:0] LAST_VOICE = IW'(VOICES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Picks the eight LFSR taps that form the top byte of the noise sample.
    function automatic logic [11:0] noise_map(input logic [22:0] l);
        noise_map = {l[22], l[20], l[16], l[13], l[11], l[7], l[4], l[2], 4'b0000};
    endfunction

    state_t          state_r;
    state_t          state_nxt_s;
    logic [IW-1:0]   voice_r;
    logic [IW-1:0]   voice_nxt_s;
    logic [23:0]     acc_r  [VOICES];
    logic [22:0]     lfsr_r [VOICES];
    logic [15:0]     freq_r [VOICES];
    logic [23:0]     acc_sum_s;
    logic            step_s;
    logic [23:0]     acc_wb_s;
    logic [22:0]     lfsr_wb_s;
    logic [11:0]     dout_r;
    logic [IW-1:0]   dout_voice_r;
    logic            dout_valid_r;
    logic            busy_r;
    logic            overrun_r;

    // Sweep control and the shared per-voice update datapath.
    always_comb begin
        state_nxt_s = state_r;
        voice_nxt_s = voice_r;
        acc_sum_s   = acc_r[voice_r] + {8'h00, freq_r[voice_r]};
        step_s      = !acc_r[voice_r][19] && acc_sum_s[19];
        acc_wb_s    = acc_sum_s;
        lfsr_wb_s   = lfsr_r[voice_r];
        if (test[voice_r]) begin
            acc_wb_s  = 24'h000000;
            lfsr_wb_s = SEED;
        end else if (step_s) begin
            lfsr_wb_s = {lfsr_r[voice_r][21:0], lfsr_r[voice_r][22] ^ lfsr_r[voice_r][17]};
        end else begin
            lfsr_wb_s = lfsr_r[voice_r];
        end
        case (state_r)
            IDLE: begin
                if (sample_tick) begin
                    state_nxt_s = RUN;
                    voice_nxt_s = {IW{1'b0}};
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (voice_r == LAST_VOICE) begin
                    state_nxt_s = IDLE;
                    voice_nxt_s = {IW{1'b0}};
                end else begin
                    voice_nxt_s = voice_r + IW'(1);
                end
            end
            default: begin
                state_nxt_s = IDLE;
                voice_nxt_s = {IW{1'b0}};
            end
        endcase
    end

    // State, per-voice accumulator/LFSR writeback and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            voice_r      <= {IW{1'b0}};
            dout_r       <= 12'h000;
            dout_voice_r <= {IW{1'b0}};
            dout_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            overrun_r    <= 1'b0;
            for (int i = 0; i < VOICES; i++) begin
                acc_r[i]  <= 24'h000000;
                lfsr_r[i] <= SEED;
            end
        end else begin
            state_r <= state_nxt_s;
            voice_r <= voice_nxt_s;
            busy_r  <= (state_nxt_s == RUN);
            if (sample_tick && (state_r != IDLE)) begin
                overrun_r <= 1'b1;
            end
            if (state_r == RUN) begin
                acc_r[voice_r]  <= acc_wb_s;
                lfsr_r[voice_r] <= lfsr_wb_s;
                dout_r          <= noise_map(lfsr_wb_s);
                dout_voice_r    <= voice_r;
                dout_valid_r    <= 1'b1;
            end else begin
                dout_valid_r    <= 1'b0;
            end
        end
    end

    // Frequency register file; a same-cycle write to the active voice takes effect next sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < VOICES; i++) begin
                freq_r[i] <= 16'h0000;
            end
        end else begin
            if (freq_wr_en && (32'(freq_wr_addr) < VOICES)) begin
                freq_r[freq_wr_addr] <= freq_wr_data;
            end
        end
    end

    assign dout       = dout_r;
    assign dout_voice = dout_voice_r;
    assign dout_valid = dout_valid_r;
    assign busy       = busy_r;
    assign overrun    = overrun_r;

endmodule

// File: tb/tb_noise_voice_sequencer.sv
// Scoreboard bench for noise_voice_sequencer: a behavioural voice model pushes the
// expected samples of each sweep; a monitor pops and compares on every dout_valid.
module tb_noise_voice_sequencer;

    localparam int VOICES = 4;
    localparam int IW = $clog2(VOICES);
    localparam logic [22:0] SEED = 23'h37242B;

    typedef struct packed {
        logic [IW-1:0] voice;
        logic [11:0]   data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sample_tick = 1'b0;
    logic              freq_wr_en = 1'b0;
    logic [IW-1:0]     freq_wr_addr = '0;
    logic [15:0]       freq_wr_data = 16'h0000;
    logic [VOICES-1:0] test = '0;
    logic [11:0]       dout;
    logic [IW-1:0]     dout_voice;
    logic              dout_valid;
    logic              busy;
    logic              overrun;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];
    logic [11:0] last_dout [VOICES];

    logic [23:0] acc_m  [VOICES];
    logic [22:0] lfsr_m [VOICES];
    logic [15:0] freq_m [VOICES];

    noise_voice_sequencer #(.VOICES(VOICES)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_tick  (sample_tick),
        .freq_wr_en   (freq_wr_en),
        .freq_wr_addr (freq_wr_addr),
        .freq_wr_data (freq_wr_data),
        .test         (test),
        .dout         (dout),
        .dout_voice   (dout_voice),
        .dout_valid   (dout_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] sample_of(input logic [22:0] l);
        sample_of = {l[22], l[20], l[16], l[13], l[11], l[7], l[4], l[2], 4'b0000};
    endfunction

    task automatic model_reset();
        for (int v = 0; v < VOICES; v++) begin
            acc_m[v]  = 24'h000000;
            lfsr_m[v] = SEED;
            freq_m[v] = 16'h0000;
        end
    endtask

    // Advance every voice of the model by one sweep; expect the first n samples.
    task automatic model_sweep(input int n);
        logic [23:0] nxt;
        exp_t e;
        for (int v = 0; v < VOICES; v++) begin
            if (test[v]) begin
                acc_m[v]  = 24'h000000;
                lfsr_m[v] = SEED;
            end else begin
                nxt = acc_m[v] + {8'h00, freq_m[v]};
                if (!acc_m[v][19] && nxt[19])
                    lfsr_m[v] = {lfsr_m[v][21:0], lfsr_m[v][22] ^ lfsr_m[v][17]};
                acc_m[v] = nxt;
            end
            if (v < n) begin
                e.voice = IW'(v);
                e.data  = sample_of(lfsr_m[v]);
                sb_q.push_back(e);
            end
        end
    endtask

    task automatic do_tick();
        @(negedge clk);
        sample_tick = 1'b1;
        model_sweep(VOICES);
        @(negedge clk);
        sample_tick = 1'b0;
        for (int i = 0; i <= VOICES; i++) begin
            if (i > 0) @(negedge clk);
            check_val("busy", 32'(busy), 32'(i < VOICES));
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic write_freq(input logic [IW-1:0] a, input logic [15:0] d);
        @(negedge clk);
        freq_wr_en   = 1'b1;
        freq_wr_addr = a;
        freq_wr_data = d;
        freq_m[a]    = d;
        @(negedge clk);
        freq_wr_en   = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_dout"}, 32'(dout), 32'h0);
        check_val({tag, "_voice"}, 32'(dout_voice), 32'h0);
        check_val({tag, "_valid"}, 32'(dout_valid), 32'h0);
        check_val({tag, "_busy"}, 32'(busy), 32'h0);
        check_val({tag, "_overrun"}, 32'(overrun), 32'h0);
    endtask

    // Scoreboard monitor: every valid pulse must match the oldest expected sample.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && dout_valid) begin
            check_val("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check_val("sb_voice", 32'(dout_voice), 32'(e.voice));
                check_val("sb_dout", 32'(dout), 32'(e.data));
                last_dout[dout_voice] = dout;
            end
        end
    end

    initial begin
        model_reset();
        for (int v = 0; v < VOICES; v++) last_dout[v] = 12'hFFF;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");

        // All frequencies zero: every voice emits the seed sample.
        do_tick();
        for (int v = 0; v < VOICES; v++) check_val("freq0_seed", 32'(last_dout[v]), 32'h700);

        // Voice 0 at 0x8000: first step at tick 16, bit-19 fall at 32, second step at 48.
        write_freq('0, 16'h8000);
        for (int k = 1; k <= 48; k++) begin
            do_tick();
            if (k == 15) check_val("v0_tick15", 32'(last_dout[0]), 32'h700);
            if (k == 16) check_val("v0_tick16", 32'(last_dout[0]), 32'h8B0);
            if (k == 32) check_val("v0_tick32", 32'(last_dout[0]), 32'h8B0);
            if (k == 47) check_val("v0_tick47", 32'(last_dout[0]), 32'h8B0);
            if (k == 48) check_val("v0_tick48", 32'(last_dout[0]), 32'hC50);
            if (k == 48) check_val("v1_tick48", 32'(last_dout[1]), 32'h700);
        end

        // Test bit forces seed and clears the accumulator; stepping resumes after 16 ticks.
        test = 4'b0001;
        do_tick();
        check_val("test_seed", 32'(last_dout[0]), 32'h700);
        test = 4'b0000;
        for (int k = 1; k <= 16; k++) begin
            do_tick();
            if (k == 15) check_val("rel_tick15", 32'(last_dout[0]), 32'h700);
            if (k == 16) check_val("rel_tick16", 32'(last_dout[0]), 32'h8B0);
        end

        // Dropped tick sets overrun; a write to voice 2 during its slot waits a sweep.
        check_val("overrun_clear", 32'(overrun), 32'h0);
        @(negedge clk);
        sample_tick = 1'b1;
        model_sweep(VOICES);
        @(negedge clk);
        sample_tick = 1'b0;
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick  = 1'b0;
        freq_wr_en   = 1'b1;
        freq_wr_addr = IW'(2);
        freq_wr_data = 16'hFFFF;
        @(negedge clk);
        freq_wr_en   = 1'b0;
        freq_m[2]    = 16'hFFFF;
        repeat (6) @(negedge clk);
        check_val("overrun_set", 32'(overrun), 32'h1);
        for (int k = 1; k <= 9; k++) begin
            do_tick();
            if (k == 8) check_val("v2_pre_step", 32'(last_dout[2]), 32'h700);
            if (k == 9) check_val("v2_step", 32'(last_dout[2]), 32'h8B0);
        end
        check_val("overrun_sticky", 32'(overrun), 32'h1);

        // Reset in the middle of a sweep: only voices 0 and 1 are emitted.
        @(negedge clk);
        sample_tick = 1'b1;
        model_sweep(2);
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("midreset");
        rst = 1'b0;
        model_reset();
        do_tick();
        for (int v = 0; v < VOICES; v++) check_val("post_reset_seed", 32'(last_dout[v]), 32'h700);

        repeat (5) @(negedge clk);
        check_val("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
